// File: rtl/bram_sp_arbiter_pkg.sv
// Shared identifiers and tag layout for the two-port BRAM arbiter.
package bram_sp_arbiter_pkg;

    localparam int unsigned TAG_ID_W = 1;
    localparam logic [TAG_ID_W-1:0] ID_S0 = 1'b0;
    localparam logic [TAG_ID_W-1:0] ID_S1 = 1'b1;

    // One stage of the read-tracking pipe: read in flight and its owner.
    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/bram_sp_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, priority flips to the loser on every grant.
module bram_sp_arbiter_rr_arb2
    import bram_sp_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req,
    output logic [1:0]          gnt_c,
    output logic                gnt_vld_c,
    output logic [TAG_ID_W-1:0] gnt_id_c
);

    logic [TAG_ID_W-1:0] prio_q;
    logic [TAG_ID_W-1:0] prio_d;

    // prio_q names the port that wins when both request.
    always_comb begin
        gnt_c     = 2'b00;
        gnt_vld_c = 1'b0;
        gnt_id_c  = ID_S0;
        prio_d    = prio_q;
        case (req)
            2'b01:   gnt_c = 2'b01;
            2'b10:   gnt_c = 2'b10;
            2'b11:   gnt_c = (prio_q == ID_S1) ? 2'b10 : 2'b01;
            default: gnt_c = 2'b00;
        endcase
        gnt_vld_c = |gnt_c;
        gnt_id_c  = gnt_c[1] ? ID_S1 : ID_S0;
        if (gnt_vld_c) begin
            prio_d = ~gnt_id_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= ID_S0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/bram_sp_arbiter.sv
// Shares one single-port BRAM between two valid/ready requesters and routes
// read data back to the owner after the fixed BRAM read latency.
module bram_sp_arbiter
    import bram_sp_arbiter_pkg::*;
#(
    parameter int unsigned mem_width    = 32,
    parameter int unsigned addr_width   = 12,
    parameter int unsigned wen_width    = 1,
    parameter int unsigned read_latency = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s0_req_valid,
    output logic                  s0_req_ready,
    input  logic [wen_width-1:0]  s0_req_wen,
    input  logic [addr_width-1:0] s0_req_addr,
    input  logic [mem_width-1:0]  s0_req_din,
    output logic                  s0_rsp_valid,
    output logic [mem_width-1:0]  s0_rsp_data,
    input  logic                  s1_req_valid,
    output logic                  s1_req_ready,
    input  logic [wen_width-1:0]  s1_req_wen,
    input  logic [addr_width-1:0] s1_req_addr,
    input  logic [mem_width-1:0]  s1_req_din,
    output logic                  s1_rsp_valid,
    output logic [mem_width-1:0]  s1_rsp_data,
    output logic                  bram_en,
    output logic [wen_width-1:0]  bram_wen,
    output logic [addr_width-1:0] bram_addr,
    output logic [mem_width-1:0]  bram_din,
    input  logic [mem_width-1:0]  bram_dout
);

    localparam int unsigned LAST = read_latency - 1;

    if (read_latency < 1 || read_latency > 2) begin : g_bad_latency
        $error("bram_sp_arbiter: read_latency must be 1 or 2");
    end

    logic [1:0]          gnt;
    logic                gnt_vld;
    logic [TAG_ID_W-1:0] gnt_id;
    logic                is_read;

    tag_t [read_latency-1:0] tag_q;
    tag_t [read_latency-1:0] tag_d;

    bram_sp_arbiter_rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       ({s1_req_valid, s0_req_valid}),
        .gnt_c     (gnt),
        .gnt_vld_c (gnt_vld),
        .gnt_id_c  (gnt_id)
    );

    assign s0_req_ready = gnt[0];
    assign s1_req_ready = gnt[1];

    // BRAM port mux; everything parks at zero when no transfer is accepted.
    always_comb begin
        bram_en   = gnt_vld;
        bram_wen  = '0;
        bram_addr = '0;
        bram_din  = '0;
        if (gnt_vld) begin
            if (gnt_id == ID_S1) begin
                bram_wen  = s1_req_wen;
                bram_addr = s1_req_addr;
                bram_din  = s1_req_din;
            end else begin
                bram_wen  = s0_req_wen;
                bram_addr = s0_req_addr;
                bram_din  = s0_req_din;
            end
        end
        is_read = gnt_vld && (bram_wen == '0);
    end

    // Free-running tag shift; the last stage lines up with bram_dout.
    always_comb begin
        tag_d        = tag_q;
        tag_d[0].vld = is_read;
        tag_d[0].id  = gnt_id;
        for (int unsigned i = 1; i < read_latency; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign s0_rsp_valid = tag_q[LAST].vld && (tag_q[LAST].id == ID_S0);
    assign s1_rsp_valid = tag_q[LAST].vld && (tag_q[LAST].id == ID_S1);
    assign s0_rsp_data  = bram_dout;
    assign s1_rsp_data  = bram_dout;

endmodule

// File: tb/tb_bram_sp_arbiter.sv
// Scoreboard bench: directed scenarios plus random traffic against a shadow-memory reference.
module tb_bram_sp_arbiter;

    localparam int unsigned MW = 32;
    localparam int unsigned AW = 12;
    localparam int unsigned WW = 1;
    localparam int unsigned L  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s0_req_valid, s0_req_ready, s0_rsp_valid;
    logic [WW-1:0] s0_req_wen;
    logic [AW-1:0] s0_req_addr;
    logic [MW-1:0] s0_req_din, s0_rsp_data;
    logic          s1_req_valid, s1_req_ready, s1_rsp_valid;
    logic [WW-1:0] s1_req_wen;
    logic [AW-1:0] s1_req_addr;
    logic [MW-1:0] s1_req_din, s1_rsp_data;
    logic          bram_en;
    logic [WW-1:0] bram_wen;
    logic [AW-1:0] bram_addr;
    logic [MW-1:0] bram_din, bram_dout;

    always #5 clk = ~clk;

    bram_sp_arbiter #(
        .mem_width(MW), .addr_width(AW), .wen_width(WW), .read_latency(L)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_req_valid(s0_req_valid), .s0_req_ready(s0_req_ready), .s0_req_wen(s0_req_wen),
        .s0_req_addr(s0_req_addr), .s0_req_din(s0_req_din),
        .s0_rsp_valid(s0_rsp_valid), .s0_rsp_data(s0_rsp_data),
        .s1_req_valid(s1_req_valid), .s1_req_ready(s1_req_ready), .s1_req_wen(s1_req_wen),
        .s1_req_addr(s1_req_addr), .s1_req_din(s1_req_din),
        .s1_rsp_valid(s1_rsp_valid), .s1_rsp_data(s1_rsp_data),
        .bram_en(bram_en), .bram_wen(bram_wen), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout)
    );

    // Single-port BRAM, read-first, output pipeline matching L.
    logic [MW-1:0] mem [0:(1<<AW)-1];
    logic [MW-1:0] rd1, rd2;
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        rd1 = '0;
        rd2 = '0;
    end
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_wen != '0) mem[bram_addr] <= bram_din;
            rd1 <= mem[bram_addr];
        end
        rd2 <= rd1;
    end
    assign bram_dout = (L == 1) ? rd1 : rd2;

    typedef struct {
        logic [MW-1:0] data;
        int unsigned   cyc;
    } exp_t;

    exp_t          q0[$];
    exp_t          q1[$];
    logic [MW-1:0] shadow [int unsigned];
    logic          m_prio_s1 = 1'b0;
    int unsigned   compared   = 0;
    int unsigned   mismatched = 0;
    int unsigned   cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: grant from valids and who was served last; reads snapshot the shadow memory.
    logic          g0, g1;
    logic [WW-1:0] ew;
    logic [AW-1:0] ea;
    logic [MW-1:0] ed;
    exp_t          e_push;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prio_s1 = 1'b0;
        end else begin
            g0 = s0_req_valid && (!s1_req_valid || !m_prio_s1);
            g1 = s1_req_valid && (!s0_req_valid ||  m_prio_s1);
            check("s0_req_ready", 64'(s0_req_ready), 64'(g0));
            check("s1_req_ready", 64'(s1_req_ready), 64'(g1));
            check("bram_en", 64'(bram_en), 64'(g0 || g1));
            if (g0 || g1) begin
                ew = g1 ? s1_req_wen  : s0_req_wen;
                ea = g1 ? s1_req_addr : s0_req_addr;
                ed = g1 ? s1_req_din  : s0_req_din;
                check("bram_addr", 64'(bram_addr), 64'(ea));
                check("bram_wen",  64'(bram_wen),  64'(ew));
                if (ew != '0) begin
                    check("bram_din", 64'(bram_din), 64'(ed));
                    shadow[32'(ea)] = ed;
                end else begin
                    e_push.data = shadow.exists(32'(ea)) ? shadow[32'(ea)] : '0;
                    e_push.cyc  = cyc;
                    if (g1) q1.push_back(e_push);
                    else    q0.push_back(e_push);
                end
                m_prio_s1 = g0;
            end else begin
                check("idle_bram_wen", 64'(bram_wen), 64'(0));
                check("idle_bram_addr", 64'(bram_addr), 64'(0));
            end
        end
    end

    // Monitor: every response must match the oldest outstanding read of that port.
    exp_t e_pop;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else begin
            if (s0_rsp_valid) begin
                if (q0.size() == 0) begin
                    check("s0_unexpected_rsp", 64'(1), 64'(0));
                end else begin
                    e_pop = q0.pop_front();
                    check("s0_rsp_data", 64'(s0_rsp_data), 64'(e_pop.data));
                    check("s0_rsp_latency", 64'(cyc - e_pop.cyc), 64'(L));
                end
            end
            if (s1_rsp_valid) begin
                if (q1.size() == 0) begin
                    check("s1_unexpected_rsp", 64'(1), 64'(0));
                end else begin
                    e_pop = q1.pop_front();
                    check("s1_rsp_data", 64'(s1_rsp_data), 64'(e_pop.data));
                    check("s1_rsp_latency", 64'(cyc - e_pop.cyc), 64'(L));
                end
            end
        end
    end

    logic acc0, acc1, prev0;

    task automatic tick();
        @(negedge clk);
        acc0 = s0_req_valid && s0_req_ready;
        acc1 = s1_req_valid && s1_req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [WW-1:0] w, input logic [AW-1:0] a, input logic [MW-1:0] d);
        s0_req_valid = v; s0_req_wen = w; s0_req_addr = a; s0_req_din = d;
    endtask

    task automatic set1(input logic v, input logic [WW-1:0] w, input logic [AW-1:0] a, input logic [MW-1:0] d);
        s1_req_valid = v; s1_req_wen = w; s1_req_addr = a; s1_req_din = d;
    endtask

    task automatic idle(input int n);
        set0(1'b0, '0, '0, '0);
        set1(1'b0, '0, '0, '0);
        repeat (n) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        set0(1'b0, '0, '0, '0);
        set1(1'b0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_s0_rsp_valid", 64'(s0_rsp_valid), 64'(0));
        check("reset_s1_rsp_valid", 64'(s1_rsp_valid), 64'(0));
        rst_n = 1'b1;

        // Out of reset both valid: s0 first, then s1.
        set0(1'b1, '0, 12'h005, '0);
        set1(1'b1, '0, 12'h006, '0);
        tick();
        check("t3_first_is_s0", 64'({acc1, acc0}), 64'(2'b01));
        set0(1'b0, '0, '0, '0);
        tick();
        check("t3_then_s1", 64'({acc1, acc0}), 64'(2'b10));
        idle(L + 2);

        // s0 write then read back.
        set0(1'b1, 1'b1, 12'h010, 32'hA5A5_0001);
        tick();
        set0(1'b1, 1'b0, 12'h010, '0);
        tick();
        idle(L + 2);

        // Both ports reading continuously: strict alternation.
        set0(1'b1, 1'b1, 12'h001, 32'h1111_0001);
        tick();
        set0(1'b0, '0, '0, '0);
        set1(1'b1, 1'b1, 12'h002, 32'h2222_0002);
        tick();
        set0(1'b1, 1'b0, 12'h001, '0);
        set1(1'b1, 1'b0, 12'h002, '0);
        prev0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t2_one_grant", 64'(acc0 ^ acc1), 64'(1));
            if (i > 0) check("t2_alternate", 64'(acc0), 64'(!prev0));
            prev0 = acc0;
        end
        idle(L + 2);

        // Write by s1, read of the same word by s0 the next cycle.
        set1(1'b1, 1'b1, 12'h3FF, 32'h0000_00FF);
        tick();
        set1(1'b0, '0, '0, '0);
        set0(1'b1, 1'b0, 12'h3FF, '0);
        tick();
        idle(L + 2);

        // Two reads in flight, then reset: nothing returns, priority back to s0.
        set1(1'b1, 1'b0, 12'h010, '0);
        tick();
        set1(1'b0, '0, '0, '0);
        set0(1'b1, 1'b0, 12'h3FF, '0);
        tick();
        set0(1'b0, '0, '0, '0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        check("t5_s0_rsp_after_rst", 64'(s0_rsp_valid), 64'(0));
        check("t5_s1_rsp_after_rst", 64'(s1_rsp_valid), 64'(0));
        idle(L + 2);
        set0(1'b1, 1'b0, 12'h010, '0);
        set1(1'b1, 1'b0, 12'h3FF, '0);
        tick();
        check("t5_prio_reset_s0", 64'({acc1, acc0}), 64'(2'b01));
        set0(1'b0, '0, '0, '0);
        tick();
        idle(L + 2);

        // s0 alone for 8 cycles: no bubbles.
        for (int i = 0; i < 8; i++) begin
            set0(1'b1, WW'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
            tick();
            check("t6_s0_every_cycle", 64'(acc0), 64'(1));
        end
        idle(L + 2);

        // Random traffic; a port holds its request until accepted.
        for (int i = 0; i < 400; i++) begin
            if (!s0_req_valid || acc0)
                set0($urandom_range(0, 9) < 6, WW'($urandom_range(0, 1)),
                     AW'($urandom_range(0, 15)), $urandom);
            if (!s1_req_valid || acc1)
                set1($urandom_range(0, 9) < 6, WW'($urandom_range(0, 1)),
                     AW'($urandom_range(0, 15)), $urandom);
            acc0 = 1'b0;
            acc1 = 1'b0;
            tick();
        end
        idle(L + 3);

        check("s0_drain", 64'(q0.size()), 64'(0));
        check("s1_drain", 64'(q1.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
